program_loader: RTL and testbench

Sequential writer that fills the program memory later read by the instruction-pointer fetch path. It accepts a stream of 4-bit opcodes over a valid/ready handshake and decodes each one back to its Brainfuck ASCII symbol, which is the inverse of the symbol-to-opcode encoder. It writes each symbol at an auto-incrementing address and tracks loop nesting so that unbalanced programs are rejected before execution. It sits between the host/test stimulus and the program RAM that backs the instruction ROM.

---
 rtl/program_loader_pkg.sv | 38 +++
 rtl/opcode_decoder.sv | 39 +++
 rtl/program_loader.sv | 141 ++++++++++++++
 tb/tb_program_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared opcode/symbol constants, loader error codes and FSM state type.
package program_loader_pkg;

    localparam logic [3:0] OP_HALT  = 4'd0;
    localparam logic [3:0] OP_INC   = 4'd1;
    localparam logic [3:0] OP_DEC   = 4'd2;
    localparam logic [3:0] OP_RIGHT = 4'd3;
    localparam logic [3:0] OP_LEFT  = 4'd4;
    localparam logic [3:0] OP_OPEN  = 4'd5;
    localparam logic [3:0] OP_CLOSE = 4'd6;
    localparam logic [3:0] OP_OUT   = 4'd7;
    localparam logic [3:0] OP_IN    = 4'd8;

    localparam logic [7:0] SYM_HALT  = 8'h00;
    localparam logic [7:0] SYM_INC   = 8'h2B;
    localparam logic [7:0] SYM_DEC   = 8'h2D;
    localparam logic [7:0] SYM_RIGHT = 8'h3E;
    localparam logic [7:0] SYM_LEFT  = 8'h3C;
    localparam logic [7:0] SYM_OPEN  = 8'h5B;
    localparam logic [7:0] SYM_CLOSE = 8'h5D;
    localparam logic [7:0] SYM_OUT   = 8'h2E;
    localparam logic [7:0] SYM_IN    = 8'h2C;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
    localparam logic [2:0] ERR_FULL      = 3'd3;
    localparam logic [2:0] ERR_UNCLOSED  = 3'd4;
    localparam logic [2:0] ERR_INVALID   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode-to-ASCII decoder with bracket/halt/validity flags.
module opcode_decoder
    import program_loader_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [7:0] symbol,
    output logic       is_valid,
    output logic       is_open,
    output logic       is_close,
    output logic       is_halt
);

    always_comb begin
        symbol   = SYM_HALT;
        is_valid = 1'b1;
        is_open  = 1'b0;
        is_close = 1'b0;
        is_halt  = 1'b0;
        case (opcode)
            OP_HALT:  is_halt = 1'b1;
            OP_INC:   symbol = SYM_INC;
            OP_DEC:   symbol = SYM_DEC;
            OP_RIGHT: symbol = SYM_RIGHT;
            OP_LEFT:  symbol = SYM_LEFT;
            OP_OPEN: begin
                symbol  = SYM_OPEN;
                is_open = 1'b1;
            end
            OP_CLOSE: begin
                symbol   = SYM_CLOSE;
                is_close = 1'b1;
            end
            OP_OUT:   symbol = SYM_OUT;
            OP_IN:    symbol = SYM_IN;
            default:  is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/program_loader.sv
// Streams opcodes into program RAM as ASCII symbols, checking bracket balance.
// Define PROGRAM_LOADER_CHECKSUM_EN to enable the running symbol checksum.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int MAX_ADDR    = 1000,
    parameter int DEPTH_WIDTH = 7,
    parameter int MAX_DEPTH   = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             opcode_in,
    input  logic                   opcode_valid,
    output logic                   opcode_ready,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [7:0]             mem_data,
    output logic                   mem_we,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [2:0]             err_code,
    output logic [DEPTH_WIDTH-1:0] loop_depth,
    output logic [ADDR_WIDTH-1:0]  prog_len,
    output logic [7:0]             checksum
);

    localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST = ADDR_WIDTH'(MAX_ADDR - 1);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = DEPTH_WIDTH'(MAX_DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            dec_symbol;
    logic                  dec_valid;
    logic                  dec_open;
    logic                  dec_close;
    logic                  dec_halt;
    logic [2:0]            err_sel;

    opcode_decoder u_decoder (
        .opcode   (opcode_in),
        .symbol   (dec_symbol),
        .is_valid (dec_valid),
        .is_open  (dec_open),
        .is_close (dec_close),
        .is_halt  (dec_halt)
    );

    // Priority chain: the lowest error code wins when checks overlap.
    always_comb begin
        err_sel = ERR_NONE;
        if (dec_close && loop_depth == '0)
            err_sel = ERR_UNDERFLOW;
        else if (dec_open && loop_depth == DEPTH_MAX)
            err_sel = ERR_OVERFLOW;
        else if (!dec_halt && wr_addr == ADDR_LAST)
            err_sel = ERR_FULL;
        else if (dec_halt && loop_depth != '0)
            err_sel = ERR_UNCLOSED;
        else if (!dec_valid)
            err_sel = ERR_INVALID;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wr_addr      <= '0;
            opcode_ready <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_we       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
            loop_depth   <= '0;
            prog_len     <= '0;
        end else begin
            mem_we <= 1'b0;
            // START from any state (including mid-load) restarts at address 0.
            if (start) begin
                state        <= ST_LOAD;
                wr_addr      <= '0;
                opcode_ready <= 1'b1;
                mem_addr     <= '0;
                busy         <= 1'b1;
                done         <= 1'b0;
                error        <= 1'b0;
                err_code     <= ERR_NONE;
                loop_depth   <= '0;
                prog_len     <= '0;
            end else if (state == ST_LOAD && opcode_valid) begin
                if (err_sel != ERR_NONE) begin
                    state        <= ST_ERROR;
                    opcode_ready <= 1'b0;
                    busy         <= 1'b0;
                    error        <= 1'b1;
                    err_code     <= err_sel;
                end else if (dec_halt) begin
                    state        <= ST_DONE;
                    opcode_ready <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    mem_we       <= 1'b1;
                    mem_addr     <= wr_addr;
                    mem_data     <= SYM_HALT;
                end else begin
                    mem_we   <= 1'b1;
                    mem_addr <= wr_addr;
                    mem_data <= dec_symbol;
                    wr_addr  <= wr_addr + 1'b1;
                    prog_len <= prog_len + 1'b1;
                    if (dec_open)
                        loop_depth <= loop_depth + 1'b1;
                    else if (dec_close)
                        loop_depth <= loop_depth - 1'b1;
                end
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic write_ok;

    assign write_ok = (state == ST_LOAD) && opcode_valid && (err_sel == ERR_NONE);

    // The terminator adds 0x00, so summing every clean accept covers it.
    always_ff @(posedge clk) begin
        if (!rst_n)
            checksum <= '0;
        else if (start)
            checksum <= '0;
        else if (write_ok)
            checksum <= checksum + dec_symbol;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader (default and MAX_ADDR=4 instances).
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  opcode_in = 4'd0;
    logic        opcode_valid = 1'b0;

    logic        ready_a, we_a, busy_a, done_a, error_a;
    logic [15:0] addr_a, len_a;
    logic [7:0]  data_a, cks_a;
    logic [2:0]  code_a;
    logic [6:0]  depth_a;

    logic        ready_b, we_b, busy_b, done_b, error_b;
    logic [15:0] addr_b, len_b;
    logic [7:0]  data_b, cks_b;
    logic [2:0]  code_b;
    logic [6:0]  depth_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        done;
        logic        ready;
        logic [6:0]  depth;
        logic [15:0] len;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    program_loader dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode_in(opcode_in),
        .opcode_valid(opcode_valid), .opcode_ready(ready_a), .mem_addr(addr_a),
        .mem_data(data_a), .mem_we(we_a), .busy(busy_a), .done(done_a),
        .error(error_a), .err_code(code_a), .loop_depth(depth_a),
        .prog_len(len_a), .checksum(cks_a)
    );

    program_loader #(.MAX_ADDR(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode_in(opcode_in),
        .opcode_valid(opcode_valid), .opcode_ready(ready_b), .mem_addr(addr_b),
        .mem_data(data_b), .mem_we(we_b), .busy(busy_b), .done(done_b),
        .error(error_b), .err_code(code_b), .loop_depth(depth_b),
        .prog_len(len_b), .checksum(cks_b)
    );

    task automatic applyStimulus(input logic s, input logic v, input logic [3:0] op);
        start        = s;
        opcode_valid = v;
        opcode_in    = op;
        @(posedge clk);
        #1;
        start        = 1'b0;
        opcode_valid = 1'b0;
        opcode_in    = 4'd0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " ready"}, 32'(ready_a), 0);
        checkOutput({tag, " we"},    32'(we_a),    0);
        checkOutput({tag, " addr"},  32'(addr_a),  0);
        checkOutput({tag, " data"},  32'(data_a),  0);
        checkOutput({tag, " busy"},  32'(busy_a),  0);
        checkOutput({tag, " done"},  32'(done_a),  0);
        checkOutput({tag, " error"}, 32'(error_a), 0);
        checkOutput({tag, " code"},  32'(code_a),  0);
        checkOutput({tag, " depth"}, 32'(depth_a), 0);
        checkOutput({tag, " len"},   32'(len_a),   0);
        checkOutput({tag, " cks"},   32'(cks_a),   0);
    endtask

    initial begin
        logic [7:0] cks_model;
        int we_count;

        vecs[0] = '{op: 4'd1, we: 1'b1, addr: 16'd0, data: 8'h2B, done: 1'b0, ready: 1'b1, depth: 7'd0, len: 16'd1};
        vecs[1] = '{op: 4'd3, we: 1'b1, addr: 16'd1, data: 8'h3E, done: 1'b0, ready: 1'b1, depth: 7'd0, len: 16'd2};
        vecs[2] = '{op: 4'd5, we: 1'b1, addr: 16'd2, data: 8'h5B, done: 1'b0, ready: 1'b1, depth: 7'd1, len: 16'd3};
        vecs[3] = '{op: 4'd2, we: 1'b1, addr: 16'd3, data: 8'h2D, done: 1'b0, ready: 1'b1, depth: 7'd1, len: 16'd4};
        vecs[4] = '{op: 4'd6, we: 1'b1, addr: 16'd4, data: 8'h5D, done: 1'b0, ready: 1'b1, depth: 7'd0, len: 16'd5};
        vecs[5] = '{op: 4'd0, we: 1'b1, addr: 16'd5, data: 8'h00, done: 1'b1, ready: 1'b0, depth: 7'd0, len: 16'd5};

        rst_n = 1'b0;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkReset("reset");
        rst_n = 1'b1;

        // Balanced program +>[-] followed by HALT.
        applyStimulus(1, 0, 0);
        checkOutput("load ready", 32'(ready_a), 1);
        checkOutput("load busy", 32'(busy_a), 1);
        cks_model = 8'h00;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, vecs[i].op);
            cks_model = cks_model + vecs[i].data;
            checkOutput($sformatf("v%0d we", i),    32'(we_a),    32'(vecs[i].we));
            checkOutput($sformatf("v%0d addr", i),  32'(addr_a),  32'(vecs[i].addr));
            checkOutput($sformatf("v%0d data", i),  32'(data_a),  32'(vecs[i].data));
            checkOutput($sformatf("v%0d done", i),  32'(done_a),  32'(vecs[i].done));
            checkOutput($sformatf("v%0d ready", i), 32'(ready_a), 32'(vecs[i].ready));
            checkOutput($sformatf("v%0d depth", i), 32'(depth_a), 32'(vecs[i].depth));
            checkOutput($sformatf("v%0d len", i),   32'(len_a),   32'(vecs[i].len));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checkOutput($sformatf("v%0d cks", i),   32'(cks_a),   32'(cks_model));
`else
            checkOutput($sformatf("v%0d cks", i),   32'(cks_a),   0);
`endif
        end
        applyStimulus(0, 0, 0);
        checkOutput("done we off", 32'(we_a), 0);
        checkOutput("done held", 32'(done_a), 1);

        // Close bracket with nothing open.
        applyStimulus(1, 0, 0);
        checkOutput("restart done clr", 32'(done_a), 0);
        applyStimulus(0, 1, 4'd6);
        checkOutput("e1 we", 32'(we_a), 0);
        checkOutput("e1 error", 32'(error_a), 1);
        checkOutput("e1 code", 32'(code_a), 1);
        checkOutput("e1 ready", 32'(ready_a), 0);
        applyStimulus(0, 1, 4'd1);
        checkOutput("e1 ignore we", 32'(we_a), 0);
        checkOutput("e1 ready held", 32'(ready_a), 0);

        // Nesting limit: 100 opens accepted, the 101st rejected.
        applyStimulus(1, 0, 0);
        checkOutput("restart err clr", 32'(error_a), 0);
        we_count = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, 1, 4'd5);
            we_count += int'(we_a);
        end
        checkOutput("e2 writes", 32'(we_count), 100);
        checkOutput("e2 last addr", 32'(addr_a), 99);
        applyStimulus(0, 1, 4'd5);
        checkOutput("e2 we", 32'(we_a), 0);
        checkOutput("e2 code", 32'(code_a), 2);
        checkOutput("e2 depth", 32'(depth_a), 100);
        checkOutput("e2 len", 32'(len_a), 100);

        // Small memory: last slot reserved for the terminator.
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 4'd1);
            checkOutput($sformatf("e3 we%0d", i), 32'(we_b), 1);
            checkOutput($sformatf("e3 addr%0d", i), 32'(addr_b), 32'(i));
        end
        applyStimulus(0, 1, 4'd1);
        checkOutput("e3 we", 32'(we_b), 0);
        checkOutput("e3 code", 32'(code_b), 3);
        checkOutput("e3 len", 32'(len_b), 3);
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'd1);
        applyStimulus(0, 1, 4'd0);
        checkOutput("full halt we", 32'(we_b), 1);
        checkOutput("full halt addr", 32'(addr_b), 3);
        checkOutput("full halt data", 32'(data_b), 0);
        checkOutput("full halt done", 32'(done_b), 1);
        checkOutput("full halt err", 32'(error_b), 0);

        // HALT with an open loop, then an invalid opcode.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 4'd5);
        applyStimulus(0, 1, 4'd0);
        checkOutput("e4 we", 32'(we_a), 0);
        checkOutput("e4 code", 32'(code_a), 4);
        checkOutput("e4 done", 32'(done_a), 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 4'd12);
        checkOutput("e5 we", 32'(we_a), 0);
        checkOutput("e5 code", 32'(code_a), 5);
        checkOutput("e5 len", 32'(len_a), 0);

        // START mid-load discards the same-cycle accept and restarts at 0.
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'd1);
        applyStimulus(1, 1, 4'd1);
        checkOutput("abort we", 32'(we_a), 0);
        checkOutput("abort len", 32'(len_a), 0);
        checkOutput("abort busy", 32'(busy_a), 1);
        applyStimulus(0, 1, 4'd2);
        checkOutput("rs w0 addr", 32'(addr_a), 0);
        checkOutput("rs w0 data", 32'(data_a), 32'h2D);
        applyStimulus(0, 1, 4'd0);
        checkOutput("rs w1 we", 32'(we_a), 1);
        checkOutput("rs w1 addr", 32'(addr_a), 1);
        checkOutput("rs w1 data", 32'(data_a), 0);
        checkOutput("rs len", 32'(len_a), 1);
        checkOutput("rs done", 32'(done_a), 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        checkOutput("rs cks", 32'(cks_a), 32'h2D);
`else
        checkOutput("rs cks", 32'(cks_a), 0);
`endif

        // Reset during a load with an accept pending on the same edge.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 4'd5);
        applyStimulus(0, 1, 4'd1);
        rst_n = 1'b0;
        applyStimulus(0, 1, 4'd1);
        checkReset("midrst");
        applyStimulus(0, 0, 0);
        checkOutput("midrst we after", 32'(we_a), 0);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
